uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
- Parametrised successor of the fixed 55-byte UART parameter loader.
- Takes a byte stream from the UART receiver and frames it into NUM_BYTES indexed payload writes: one write per byte, idx plus data plus a one-cycle update strobe.
- Adds an optional sync byte, an optional two's-complement checksum, an inter-byte timeout and a frame error flag.
- Sits between uart_top and the vertex/parameter register bank. Downstream commits a frame only on pc_ready.

Parameters:
- NUM_BYTES, 55: payload bytes per frame (2..255).
- IDX_W, 6: width of idx; must satisfy 2^IDX_W >= NUM_BYTES.
- SYNC_EN, 1: 1 = frame must start with SYNC_BYTE; 0 = first byte received is payload byte 0.
- SYNC_BYTE, 8'hA5: frame start marker.
- CHECKSUM_EN, 1: 1 = one checksum byte follows the payload.
- TIMEOUT_CYC, 1000000: maximum idle clocks between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- byte_valid  in  1  one-cycle strobe from the UART, new byte present
- byte_data  in  8  received byte, valid when byte_valid=1
- read_data  out  8  payload byte being written
- idx  out  IDX_W  payload index, 0..NUM_BYTES-1
- update_reg  out  1  one-cycle write strobe for read_data/idx
- pc_ready  out  1  one-cycle pulse: frame complete and valid
- frame_err  out  1  one-cycle pulse: frame aborted (bad checksum or timeout)
- busy  out  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, byte counter 0, checksum accumulator 0, timeout counter 0.
- All outputs are registered. update_reg, pc_ready and frame_err are never high for more than one cycle.
- States:
  - IDLE: when SYNC_EN=1, byte_valid with byte_data==SYNC_BYTE goes to PAYLOAD; any other byte is silently dropped. When SYNC_EN=0, the first byte_valid is handled as payload byte 0 in the same cycle and the FSM goes to PAYLOAD.
  - PAYLOAD: on byte_valid at cycle t, at t+1 read_data=byte_data, idx=counter and update_reg=1. Counter increments and accumulator += byte (mod 256). After byte NUM_BYTES-1: if CHECKSUM_EN=1 go to CHECK, else go to DONE.
  - CHECK: on byte_valid at t, at t+1 exactly one of the following pulses: pc_ready=1 if (accumulator + byte) mod 256 == 0, otherwise frame_err=1. The FSM returns to IDLE. The checksum byte never produces update_reg.
  - DONE (CHECKSUM_EN=0 only): entered with the final update_reg; pc_ready=1 on the next cycle, then IDLE. pc_ready therefore trails the last update_reg by exactly one cycle.
- Timeout:
  - The counter runs only in PAYLOAD and CHECK and clears on every byte_valid.
  - When it reaches TIMEOUT_CYC: frame_err=1 on the next cycle, then IDLE with counter and accumulator cleared. pc_ready is not asserted.
- On IDLE entry: counter, accumulator and idx are cleared. read_data holds its last value.
- byte_valid in the same cycle a timeout fires: the timeout wins and the byte is dropped.
- SYNC_BYTE value inside the payload: treated as ordinary data; there is no resync mid-frame.
- Back-to-back byte_valid on consecutive cycles: each byte must produce its own update_reg. This requires no stall; the design has no backpressure.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0 and no pulses.
- Widths: the byte counter is IDLE-cleared and IDX_W bits wide, with no wrap inside a frame. The accumulator is 8 bits and wraps mod 256.

Decomposition:
- Shared package uart_frame_pkg holds the state enum (IDLE, PAYLOAD, CHECK, DONE), the default SYNC_BYTE and the checksum helper function.
- One natural sub-module: frame_timeout_ctr, a cleared-on-event down/up counter with a terminal pulse, reusable by other UART consumers.
- uart_top stays outside the block; byte_valid/byte_data connect to rx_done_tick/rx_data_out.

Test Plan:
- NUM_BYTES=4, SYNC_EN=1, CHECKSUM_EN=1. Send A5,01,02,03,04,F6 -> update_reg with idx 0..3 and data 01..04; pc_ready pulses 1 cycle after F6; frame_err stays 0.
- Same frame with checksum F7 -> 4 update_reg pulses, then frame_err=1 for one cycle, pc_ready never asserted, busy=0 the cycle after.
- Send 00,33 before A5, then a valid frame -> leading bytes produce no update_reg; the frame completes normally with idx starting at 0.
- TIMEOUT_CYC=50. Send A5,01,02, then idle 60 cycles -> frame_err exactly 50 cycles after the last byte; the next valid frame loads idx 0..3.
- SYNC_EN=0, CHECKSUM_EN=0, NUM_BYTES=55. Send bytes 00..36 on consecutive cycles -> 55 update_reg pulses with idx 0..54; pc_ready one cycle after idx=54.
- Assert reset after 2 payload bytes -> all outputs 0 immediately; after release a full frame loads idx from 0.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types, defaults and checksum helper for the UART frame loader
package uart_frame_pkg;

    // Frame loader FSM states
    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Two's-complement checksum: payload sum plus checksum byte must be zero mod 256
    function automatic logic checksum_ok(input logic [7:0] acc, input logic [7:0] cks);
        logic [7:0] sum;
        sum = acc + cks;
        return (sum == 8'h00);
    endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// rtl/frame_timeout_ctr.sv - idle-cycle counter cleared on each event, flags the terminal count
module frame_timeout_ctr #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    // Just wide enough to hold LIMIT-1; a LIMIT of 0 disables the terminal flag.
    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0] TERM = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CW-1:0] count;

    // Count idle cycles while running; any event or leaving the running states restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else if (count != TERM) begin
            count <= count + 1'b1;
        end
    end

    // Terminal when the idle cycle now ending is the LIMIT-th one since the last event
    assign expire = (LIMIT != 0) && run && !clear && (count == TERM) ||
                    (LIMIT != 0) && run && clear && (count == TERM) && 1'b1;

endmodule

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - frames a UART byte stream into indexed payload register writes
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int          NUM_BYTES   = 55,
    parameter int          IDX_W       = 6,
    parameter bit          SYNC_EN     = 1'b1,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter bit          CHECKSUM_EN = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [7:0]       read_data,
    output logic [IDX_W-1:0] idx,
    output logic             update_reg,
    output logic             pc_ready,
    output logic             frame_err,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [7:0]       acc;
    logic             tmo_run;
    logic             tmo_expire;

    // Inter-byte timeout only matters once a frame has started and still expects bytes
    assign tmo_run = (state == PAYLOAD) || (state == CHECK);

    frame_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .run    (tmo_run),
        .clear  (byte_valid),
        .expire (tmo_expire)
    );

    // Frame FSM with registered payload write, completion and error strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            read_data  <= '0;
            idx        <= '0;
            update_reg <= 1'b0;
            pc_ready   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            update_reg <= 1'b0;
            pc_ready   <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        if (SYNC_EN) begin
                            if (byte_data == SYNC_BYTE) begin
                                state <= PAYLOAD;
                                busy  <= 1'b1;
                            end
                        end else begin
                            // Without a sync marker the first byte is payload byte 0
                            read_data  <= byte_data;
                            idx        <= '0;
                            update_reg <= 1'b1;
                            acc        <= byte_data;
                            cnt        <= IDX_W'(1);
                            state      <= PAYLOAD;
                            busy       <= 1'b1;
                        end
                    end
                end

                PAYLOAD: begin
                    if (tmo_expire) begin
                        // Timeout beats a coincident byte, which is dropped
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        acc       <= '0;
                        idx       <= '0;
                    end else if (byte_valid) begin
                        read_data  <= byte_data;
                        idx        <= cnt;
                        update_reg <= 1'b1;
                        acc        <= acc + byte_data;
                        if (cnt == LAST_IDX) begin
                            state <= CHECKSUM_EN ? CHECK : DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                CHECK: begin
                    if (tmo_expire) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        acc       <= '0;
                        idx       <= '0;
                    end else if (byte_valid) begin
                        if (checksum_ok(acc, byte_data)) begin
                            pc_ready <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end

                DONE: begin
                    pc_ready <= 1'b1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cnt      <= '0;
                    acc      <= '0;
                    idx      <= '0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    acc   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - directed self-checking bench for uart_frame_loader
module tb_uart_frame_loader;

    logic       clk;
    logic       reset;

    // Instance A: 4-byte frames with sync, checksum and a short timeout
    logic       bv_a;
    logic [7:0] bd_a;
    logic [7:0] rd_a;
    logic [2:0] idx_a;
    logic       upd_a;
    logic       rdy_a;
    logic       err_a;
    logic       busy_a;

    // Instance B: 55-byte raw frames, no sync, no checksum
    logic       bv_b;
    logic [7:0] bd_b;
    logic [7:0] rd_b;
    logic [5:0] idx_b;
    logic       upd_b;
    logic       rdy_b;
    logic       err_b;
    logic       busy_b;

    int pass_cnt;
    int total_cnt;

    uart_frame_loader #(
        .NUM_BYTES   (4),
        .IDX_W       (3),
        .SYNC_EN     (1'b1),
        .SYNC_BYTE   (8'hA5),
        .CHECKSUM_EN (1'b1),
        .TIMEOUT_CYC (50)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (bv_a),
        .byte_data  (bd_a),
        .read_data  (rd_a),
        .idx        (idx_a),
        .update_reg (upd_a),
        .pc_ready   (rdy_a),
        .frame_err  (err_a),
        .busy       (busy_a)
    );

    uart_frame_loader #(
        .NUM_BYTES   (55),
        .IDX_W       (6),
        .SYNC_EN     (1'b0),
        .SYNC_BYTE   (8'hA5),
        .CHECKSUM_EN (1'b0),
        .TIMEOUT_CYC (1000)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (bv_b),
        .byte_data  (bd_b),
        .read_data  (rd_b),
        .idx        (idx_b),
        .update_reg (upd_b),
        .pc_ready   (rdy_b),
        .frame_err  (err_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_a(input logic [7:0] b);
        bv_a = 1'b1;
        bd_a = b;
        @(negedge clk);
        bv_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        bv_b = 1'b1;
        bd_b = b;
        @(negedge clk);
        bv_b = 1'b0;
    endtask

    // Sync, payload 01..04 back to back, then the given checksum byte
    task automatic frame_a(input string tag, input logic [7:0] cks, input logic ok);
        send_a(8'hA5);
        chk({tag, "_sync_noupd"}, upd_a, 0);
        chk({tag, "_sync_busy"}, busy_a, 1);
        for (int i = 0; i < 4; i++) begin
            send_a(8'(i + 1));
            chk({tag, "_upd"}, upd_a, 1);
            chk({tag, "_idx"}, idx_a, i);
            chk({tag, "_data"}, rd_a, i + 1);
            chk({tag, "_noready_mid"}, rdy_a, 0);
        end
        send_a(cks);
        chk({tag, "_cks_noupd"}, upd_a, 0);
        chk({tag, "_ready"}, rdy_a, ok ? 1 : 0);
        chk({tag, "_err"}, err_a, ok ? 0 : 1);
        @(negedge clk);
        chk({tag, "_ready_1cyc"}, rdy_a, 0);
        chk({tag, "_err_1cyc"}, err_a, 0);
        chk({tag, "_idle_busy"}, busy_a, 0);
    endtask

    initial begin
        int first_err;
        int err_pulses;
        int rdy_seen;
        int b_errs;

        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1'b1;
        bv_a = 1'b0; bd_a = 8'h00;
        bv_b = 1'b0; bd_b = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_upd", upd_a, 0);
        chk("rst_rdy", rdy_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_data", rd_a, 0);
        reset = 1'b0;
        @(negedge clk);

        // Valid frame: 1+2+3+4 = 0x0A, checksum 0xF6
        frame_a("good", 8'hF6, 1'b1);

        // Bad checksum
        frame_a("badcks", 8'hF7, 1'b0);

        // Leading junk before sync is dropped
        send_a(8'h00);
        chk("junk0_noupd", upd_a, 0);
        chk("junk0_busy", busy_a, 0);
        send_a(8'h33);
        chk("junk1_noupd", upd_a, 0);
        chk("junk1_busy", busy_a, 0);
        frame_a("afterjunk", 8'hF6, 1'b1);

        // Timeout: frame_err 50 cycles after the last payload write
        send_a(8'hA5);
        send_a(8'h01);
        send_a(8'h02);
        chk("tmo_last_idx", idx_a, 1);
        first_err  = -1;
        err_pulses = 0;
        rdy_seen   = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (err_a) begin
                err_pulses++;
                if (first_err < 0) first_err = k;
            end
            if (rdy_a) rdy_seen++;
        end
        chk("tmo_latency", first_err, 50);
        chk("tmo_one_pulse", err_pulses, 1);
        chk("tmo_no_ready", rdy_seen, 0);
        chk("tmo_idle_busy", busy_a, 0);
        frame_a("aftertmo", 8'hF6, 1'b1);

        // Reset mid-frame
        send_a(8'hA5);
        send_a(8'h01);
        send_a(8'h02);
        reset = 1'b1;
        #1;
        chk("midrst_upd", upd_a, 0);
        chk("midrst_idx", idx_a, 0);
        chk("midrst_data", rd_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_rdy", rdy_a, 0);
        chk("midrst_err", err_a, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame_a("afterrst", 8'hF6, 1'b1);

        // Instance B: 55 raw bytes on consecutive cycles
        b_errs = 0;
        for (int i = 0; i < 55; i++) begin
            send_b(8'(i));
            if (upd_b !== 1'b1 || idx_b !== 6'(i) || rd_b !== 8'(i) || rdy_b !== 1'b0) b_errs++;
        end
        chk("b_stream_errs", b_errs, 0);
        chk("b_last_idx", idx_b, 54);
        chk("b_last_data", rd_b, 8'h36);
        chk("b_busy", busy_b, 1);
        @(negedge clk);
        chk("b_ready", rdy_b, 1);
        chk("b_ready_noupd", upd_b, 0);
        chk("b_no_err", err_b, 0);
        @(negedge clk);
        chk("b_ready_1cyc", rdy_b, 0);
        chk("b_idle_busy", busy_b, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
